// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase scheduler: light codes,
// approach directions and the phase enumeration.
// Pure declarations; no logic, no latency, no flow control.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED = 2'b00;
  localparam logic [1:0] LIGHT_YEL = 2'b01;
  localparam logic [1:0] LIGHT_GRN = 2'b10;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    PH_HOLD   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_ALLRED = 2'd3
  } phase_e;

endpackage

// File: rtl/phase_rr_picker.sv
// Round-robin direction picker: first demanded direction after last_dir, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; force_pick overrides the search with force_dir.
// Ports: demand[3:0] (bit0=N..bit3=W), last_dir, force_pick, force_dir -> pick, any.
module phase_rr_picker
  import traffic_pkg::*;
(
  input  logic [3:0] demand,
  input  logic [1:0] last_dir,
  input  logic       force_pick,
  input  logic [1:0] force_dir,
  output logic [1:0] pick,
  output logic       any
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    pick  = last_dir;
    found = 1'b0;
    idx   = last_dir;
    // i runs 1..4 so last_dir itself is checked last; it may be re-picked
    // when it is the only direction with demand.
    for (int i = 1; i < 5; i++) begin
      idx = last_dir + 2'(i);
      if (!found && demand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    if (force_pick) begin
      pick = force_dir;
    end
    any = (|demand) | force_pick;
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Green/yellow/all-red sequencer for four approaches with round-robin demand and one preempt.
// Latency: green appears on the edge after demand is first sampled; each phase lasts dur*TICK_DIV cycles.
// Backpressure: run=0 freezes every register; preempt holds a matching green or cuts a foreign green to yellow.
// Ports: run, green/yellow/allred_dur, req[3:0], preempt, preempt_dir ->
//        lights[7:0], active_dir, countdown_sec, phase, pending[3:0].
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int DUR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DUR_W-1:0] green_dur,
  input  logic [DUR_W-1:0] yellow_dur,
  input  logic [DUR_W-1:0] allred_dur,
  input  logic [3:0]       req,
  input  logic             preempt,
  input  logic [1:0]       preempt_dir,
  output logic [7:0]       lights,
  output logic [1:0]       active_dir,
  output logic [DUR_W-1:0] countdown_sec,
  output logic [1:0]       phase,
  output logic [3:0]       pending
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  phase_e           phase_q, phase_d;
  logic [1:0]       dir_q, dir_d;
  logic [DUR_W-1:0] cd_q, cd_d;
  logic [3:0]       pending_q, pending_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [7:0]       lights_q, lights_d;

  logic [3:0]       demand;
  logic [3:0]       green_mask;
  logic             tick, expire;
  logic [1:0]       pick;
  logic             pick_any;

  // Zero-length durations are stretched to one second.
  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  assign demand = pending_q | req;

  // Forcing is harmless outside HOLD/ALLRED-expiry since the pick is only
  // consumed there, and preempt_dir is sampled on the same cycle as the pick.
  phase_rr_picker u_picker (
    .demand     (demand),
    .last_dir   (dir_q),
    .force_pick (preempt),
    .force_dir  (preempt_dir),
    .pick       (pick),
    .any        (pick_any)
  );

  always_comb begin
    phase_d    = phase_q;
    dir_d      = dir_q;
    cd_d       = cd_q;
    pending_d  = pending_q;
    presc_d    = presc_q;
    lights_d   = lights_q;
    green_mask = (phase_q == PH_GREEN) ? (4'b0001 << dir_q) : 4'b0000;
    tick       = (presc_q == PW'(TICK_DIV - 1));
    expire     = tick && (cd_q == DUR_W'(1));

    if (run) begin
      pending_d = pending_q | (req & ~green_mask);
      presc_d   = tick ? '0 : presc_q + PW'(1);
      if (tick && (cd_q > DUR_W'(1))) begin
        cd_d = cd_q - DUR_W'(1);
      end

      unique case (phase_q)
        PH_HOLD: begin
          presc_d = '0;
          cd_d    = '0;
          if (pick_any) begin
            phase_d = PH_GREEN;
          end
        end
        PH_GREEN: begin
          if (preempt && (preempt_dir != dir_q)) begin
            phase_d = PH_YELLOW;
          end else if (preempt) begin
            // Serving the preempted direction: freeze the clock of this phase.
            presc_d = presc_q;
            cd_d    = cd_q;
          end else if (expire) begin
            phase_d = PH_YELLOW;
          end
        end
        PH_YELLOW: begin
          if (expire) begin
            phase_d = PH_ALLRED;
          end
        end
        PH_ALLRED: begin
          if (expire) begin
            phase_d = pick_any ? PH_GREEN : PH_HOLD;
            if (!pick_any) begin
              presc_d = '0;
              cd_d    = '0;
            end
          end
        end
      endcase

      // Phase entry actions: restart the prescaler and load the duration.
      if (phase_d != phase_q) begin
        presc_d = '0;
        unique case (phase_d)
          PH_GREEN: begin
            dir_d     = pick;
            cd_d      = eff_dur(green_dur);
            // Clearing the granted bit wins over a same-cycle set.
            pending_d = pending_d & ~(4'b0001 << pick);
          end
          PH_YELLOW: cd_d = eff_dur(yellow_dur);
          PH_ALLRED: cd_d = eff_dur(allred_dur);
          PH_HOLD:   cd_d = '0;
        endcase
      end
    end

    unique case (phase_d)
      PH_GREEN:  lights_d = 8'(LIGHT_GRN) << {dir_d, 1'b0};
      PH_YELLOW: lights_d = 8'(LIGHT_YEL) << {dir_d, 1'b0};
      default:   lights_d = {4{LIGHT_RED}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_HOLD;
      dir_q     <= DIR_W;
      cd_q      <= '0;
      pending_q <= '0;
      presc_q   <= '0;
      lights_q  <= '0;
    end else begin
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      cd_q      <= cd_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
      lights_q  <= lights_d;
    end
  end

  assign lights        = lights_q;
  assign active_dir    = dir_q;
  assign countdown_sec = cd_q;
  assign phase         = phase_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b1;
  logic [7:0] green_dur = 8'd2;
  logic [7:0] yellow_dur = 8'd1;
  logic [7:0] allred_dur = 8'd1;
  logic [3:0] req = 4'b0;
  logic       preempt = 1'b0;
  logic [1:0] preempt_dir = 2'd0;
  logic [7:0] lights;
  logic [1:0] active_dir;
  logic [7:0] countdown_sec;
  logic [1:0] phase;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  intersection_phase_scheduler #(.TICK_DIV(4), .DUR_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .green_dur     (green_dur),
    .yellow_dur    (yellow_dur),
    .allred_dur    (allred_dur),
    .req           (req),
    .preempt       (preempt),
    .preempt_dir   (preempt_dir),
    .lights        (lights),
    .active_dir    (active_dir),
    .countdown_sec (countdown_sec),
    .phase         (phase),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0; preempt = 1'b0; run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Number of consecutive falling edges (starting now) that show phase p.
  task automatic run_phase(input logic [1:0] p, output int n);
    n = 0;
    while (phase == p && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0; run = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (phase !== 2'd0 || lights !== 8'h00 || active_dir !== 2'd3 || countdown_sec !== 8'd0 || pending !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: phase=%0d lights=%h dir=%0d cd=%0d pend=%b, want 0 00 3 0 0000",
               phase, lights, active_dir, countdown_sec, pending);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (phase !== 2'd0 || lights !== 8'h00 || countdown_sec !== 8'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d: phase=%0d lights=%h cd=%0d, want 0 00 0", i, phase, lights, countdown_sec);
      end
    end
  endtask

  task automatic test_single_request();
    int n;
    do_reset();
    green_dur = 8'd2; yellow_dur = 8'd1; allred_dur = 8'd1;
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    checks++;
    if (phase !== 2'd1 || lights !== 8'h20 || active_dir !== 2'd2 || countdown_sec !== 8'd2 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_green_entry: phase=%0d lights=%h dir=%0d cd=%0d pend=%b, want 1 20 2 2 0000",
               phase, lights, active_dir, countdown_sec, pending);
    end
    run_phase(2'd1, n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL single_green_len: got %0d want 8", n); end
    checks++;
    if (phase !== 2'd2 || lights !== 8'h10 || countdown_sec !== 8'd1) begin
      errors++;
      $display("FAIL single_yellow: phase=%0d lights=%h cd=%0d, want 2 10 1", phase, lights, countdown_sec);
    end
    run_phase(2'd2, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL single_yellow_len: got %0d want 4", n); end
    checks++;
    if (phase !== 2'd3 || lights !== 8'h00) begin
      errors++;
      $display("FAIL single_allred: phase=%0d lights=%h, want 3 00", phase, lights);
    end
    run_phase(2'd3, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL single_allred_len: got %0d want 4", n); end
    checks++;
    if (phase !== 2'd0 || lights !== 8'h00 || countdown_sec !== 8'd0 || pending !== 4'b0) begin
      errors++;
      $display("FAIL single_hold: phase=%0d lights=%h cd=%0d pend=%b, want 0 00 0 0000",
               phase, lights, countdown_sec, pending);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_dir [6];
    int n;
    exp_dir = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    do_reset();
    green_dur = 8'd1; yellow_dur = 8'd1; allred_dur = 8'd1;
    req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (phase !== 2'd1 && n < 200) begin n++; @(negedge clk); end
      checks++;
      if (phase !== 2'd1 || active_dir !== exp_dir[k]) begin
        errors++;
        $display("FAIL rr_grant%0d: phase=%0d dir=%0d, want 1 %0d", k, phase, active_dir, exp_dir[k]);
      end
      run_phase(2'd1, n);
    end
    req = 4'b0000;
  endtask

  task automatic test_zero_duration();
    int n;
    do_reset();
    green_dur = 8'd1; yellow_dur = 8'd0; allred_dur = 8'd1;
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    run_phase(2'd1, n);
    checks++;
    if (phase !== 2'd2 || countdown_sec !== 8'd1) begin
      errors++;
      $display("FAIL zero_yellow_load: phase=%0d cd=%0d, want 2 1", phase, countdown_sec);
    end
    run_phase(2'd2, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL zero_yellow_len: got %0d want 4", n); end
  endtask

  task automatic test_preempt();
    int n;
    do_reset();
    green_dur = 8'd5; yellow_dur = 8'd1; allred_dur = 8'd1;
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    checks++;
    if (phase !== 2'd1 || active_dir !== 2'd0 || countdown_sec !== 8'd5) begin
      errors++;
      $display("FAIL pre_n_green: phase=%0d dir=%0d cd=%0d, want 1 0 5", phase, active_dir, countdown_sec);
    end
    preempt = 1'b1; preempt_dir = 2'd1;
    @(negedge clk);
    checks++;
    if (phase !== 2'd2 || lights !== 8'h01 || countdown_sec !== 8'd1) begin
      errors++;
      $display("FAIL pre_cut_yellow: phase=%0d lights=%h cd=%0d, want 2 01 1", phase, lights, countdown_sec);
    end
    run_phase(2'd2, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL pre_yellow_len: got %0d want 4", n); end
    run_phase(2'd3, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL pre_allred_len: got %0d want 4", n); end
    checks++;
    if (phase !== 2'd1 || lights !== 8'h08 || active_dir !== 2'd1 || countdown_sec !== 8'd5) begin
      errors++;
      $display("FAIL pre_e_green: phase=%0d lights=%h dir=%0d cd=%0d, want 1 08 1 5",
               phase, lights, active_dir, countdown_sec);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (phase !== 2'd1 || countdown_sec !== 8'd5) begin
      errors++;
      $display("FAIL pre_hold_green: phase=%0d cd=%0d, want 1 5", phase, countdown_sec);
    end
    preempt = 1'b0;
    run_phase(2'd1, n);
    checks++;
    if (n !== 20) begin errors++; $display("FAIL pre_release_len: got %0d want 20", n); end
  endtask

  task automatic test_pause();
    int n;
    do_reset();
    green_dur = 8'd3; yellow_dur = 8'd1; allred_dur = 8'd1;
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    run = 1'b0;
    checks++;
    if (phase !== 2'd1 || countdown_sec !== 8'd2 || lights !== 8'h08) begin
      errors++;
      $display("FAIL pause_entry: phase=%0d cd=%0d lights=%h, want 1 2 08", phase, countdown_sec, lights);
    end
    for (int i = 0; i < 50; i++) begin
      req = (i == 10) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      checks++;
      if (phase !== 2'd1 || countdown_sec !== 8'd2 || lights !== 8'h08 || pending !== 4'b0) begin
        errors++;
        $display("FAIL pause_cycle%0d: phase=%0d cd=%0d lights=%h pend=%b, want 1 2 08 0000",
                 i, phase, countdown_sec, lights, pending);
      end
    end
    req = 4'b0000;
    run = 1'b1;
    run_phase(2'd1, n);
    checks++;
    if (n + 5 !== 12) begin errors++; $display("FAIL pause_total_green: got %0d want 12", n + 5); end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_zero_duration();
    test_preempt();
    test_pause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Sequences green/yellow/all-red phases across the four approaches (N, E, S, W) of the intersection. It arbitrates vehicle demand round-robin and supports one emergency preempt. It sits between the menu controller (durations, run/pause) and the display path, driving per-direction light codes, active direction and the seconds countdown.

Parameters:
TICK_DIV, 100000000, clk cycles per 1-second tick (benches use 4)
DUR_W, 8, width of duration and countdown fields

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
run  in  1  1 = sequencing advances, 0 = freeze all state
green_dur  in  DUR_W  green phase length, seconds
yellow_dur  in  DUR_W  yellow phase length, seconds
allred_dur  in  DUR_W  all-red clearance length, seconds
req  in  4  vehicle demand, level, bit0=N bit1=E bit2=S bit3=W
preempt  in  1  emergency preempt request, level
preempt_dir  in  2  direction to serve on preempt (0=N..3=W)
lights  out  8  2 bits per direction, [1:0]=N .. [7:6]=W; 00 red, 01 yellow, 10 green
active_dir  out  2  direction currently or last granted
countdown_sec  out  DUR_W  seconds remaining in current phase
phase  out  2  0 HOLD, 1 GREEN, 2 YELLOW, 3 ALLRED
pending  out  4  latched unserved demand

Behaviour:
- Reset (async assert, sync release): phase=HOLD; lights=8'h00 (all red); active_dir=3 (W, so first search starts at N); countdown_sec=0; pending=0; prescaler=0.
- Demand latch: pending[i] <= pending[i] | req[i] each cycle. Exception: req[active_dir] is masked while phase=GREEN. On GREEN entry the granted bit clears, and the clear wins over a same-cycle set.
- Prescaler counts 0..TICK_DIV-1 and emits tick at TICK_DIV-1. It resets to 0 on every phase entry, so each phase lasts exactly dur*TICK_DIV cycles.
- Duration rule: dur is sampled at phase entry; 0 is treated as 1. countdown_sec loads the sampled value and decrements on each tick. The phase ends on a tick with countdown_sec==1.
- Pick: first direction with (pending|req) set, searching from active_dir+1 upward with wrap. It may re-pick active_dir if that is the only demand.
- HOLD: lights all red, countdown 0. If (pending|req)!=0, the next edge enters GREEN for the picked direction, so green is visible 1 cycle after req is first sampled high.
- GREEN (dir d): lights[d]=10, others 00. On expiry go to YELLOW.
- YELLOW: lights[d]=01. On expiry go to ALLRED.
- ALLRED: all 00. On expiry, if (pending|req)!=0 go to GREEN(pick); else go to HOLD.
- Preempt, when preempt=1:
  - In GREEN with d != preempt_dir: go to YELLOW next cycle, with the yellow countdown loaded.
  - In GREEN with d == preempt_dir: countdown holds at its current value and the phase does not expire while preempt is high.
  - In HOLD, or at ALLRED expiry: the pick is forced to preempt_dir regardless of pending.
  - YELLOW and ALLRED always complete; preempt never skips clearance.
- run=0: prescaler, countdown, phase and pending hold; req is still not latched; outputs hold. On resume the sequence continues where it stopped.
- Simultaneous expiry and preempt change: preempt_dir is sampled on the same cycle as the pick.
- Width: countdown never wraps below 0; all durations are unsigned.

Decomposition:
- traffic_pkg holds:
  - light codes (LIGHT_RED=2'b00, LIGHT_YEL=2'b01, LIGHT_GRN=2'b10)
  - direction constants DIR_N..DIR_W
  - phase encodings PH_HOLD, PH_GREEN, PH_YELLOW, PH_ALLRED
- One combinational sub-module, phase_rr_picker: inputs demand[3:0], last_dir[1:0], force, force_dir; outputs pick[1:0], any.
- Prescaler and FSM stay in the parent.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, then release with req=0 -> lights=00, phase=HOLD, countdown=0 for 100 cycles.
- Single request: TICK_DIV=4, green=2, yellow=1, allred=1, pulse req[2] for 1 cycle -> S green after 1 cycle for 8 cycles, yellow 4 cycles, allred 4 cycles, then HOLD; pending[2] clears on green entry.
- Round-robin: req=4'b1011 held, starting from reset -> grants N, E, W, N, E, W, with S never granted.
- Zero duration: yellow_dur=0 -> yellow lasts exactly 4 cycles (treated as 1 second).
- Preempt: N in GREEN with countdown=5, assert preempt with preempt_dir=E -> N yellow next cycle, then allred, then E green held while preempt=1; deassert -> E runs out its remaining countdown.
- Pause: drop run mid-GREEN for 50 cycles -> countdown, prescaler and lights unchanged; on resume the total green time still equals green_dur*TICK_DIV run cycles.
